// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard light sequencer: states, wind modes,
// LED patterns and the pattern-step transition function.
package hazard_pkg;

    typedef enum logic [2:0] {
        S_CALM_A,
        S_CALM_B,
        S_L,
        S_M,
        S_R
    } state_t;

    localparam logic [1:0] MODE_CALM = 2'b00;
    localparam logic [1:0] MODE_RL   = 2'b01;
    localparam logic [1:0] MODE_LR   = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    localparam logic [2:0] LIGHTS_CALM_A = 3'b101;
    localparam logic [2:0] LIGHTS_CALM_B = 3'b010;
    localparam logic [2:0] LIGHTS_L      = 3'b100;
    localparam logic [2:0] LIGHTS_M      = 3'b010;
    localparam logic [2:0] LIGHTS_R      = 3'b001;

    // Next pattern for one step; mode is already resolved, so MODE_ILL never arrives here.
    function automatic state_t next_state(state_t cur, logic [1:0] mode);
        state_t nxt;
        nxt = S_CALM_A;
        case (mode)
            MODE_RL: begin
                case (cur)
                    S_R:     nxt = S_M;
                    S_M:     nxt = S_L;
                    S_L:     nxt = S_R;
                    default: nxt = S_R;
                endcase
            end
            MODE_LR: begin
                case (cur)
                    S_L:     nxt = S_M;
                    S_M:     nxt = S_R;
                    S_R:     nxt = S_L;
                    default: nxt = S_L;
                endcase
            end
            default: begin
                nxt = (cur == S_CALM_A) ? S_CALM_B : S_CALM_A;
            end
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] lights_of(state_t s);
        logic [2:0] pat;
        case (s)
            S_CALM_A: pat = LIGHTS_CALM_A;
            S_CALM_B: pat = LIGHTS_CALM_B;
            S_L:      pat = LIGHTS_L;
            S_M:      pat = LIGHTS_M;
            S_R:      pat = LIGHTS_R;
            default:  pat = LIGHTS_CALM_A;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hazard_light_ctrl_sync2.sv
// Width-parameterised two-flop synchronizer with asynchronous active-low reset to 0.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hazard_light_ctrl.sv
// Hazard light sequencer: synchronizes the wind switches and steps a Moore LED pattern
// once per TICK_DIV cycles. Optional HAZARD_FREEZE_EN adds a freeze input that pauses stepping.
module hazard_light_ctrl
    import hazard_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] wind,
`ifdef HAZARD_FREEZE_EN
    input  logic       freeze,
`endif
    output logic [2:0] lights,
    output logic       tick,
    output logic       illegal
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [1:0]       wind_s;
    logic             hold;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic [1:0]       eff;
    logic             illegal_q;
    state_t           state_q;
    state_t           state_d;

    sync2 #(.WIDTH(2)) u_wind_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (wind),
        .q       (wind_s)
    );

`ifdef HAZARD_FREEZE_EN
    logic freeze_s;

    sync2 #(.WIDTH(1)) u_freeze_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (freeze),
        .q       (freeze_s)
    );

    assign hold = freeze_s;
`else
    assign hold = 1'b0;
`endif

    assign tick = (cnt == CNT_MAX) && !hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    // An illegal switch reading keeps following whichever legal mode was last seen.
    assign eff = (wind_s == MODE_ILL) ? mode_q : wind_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_CALM;
            illegal_q <= 1'b0;
        end else if (tick) begin
            mode_q    <= eff;
            illegal_q <= (wind_s == MODE_ILL);
        end
    end

    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_CALM_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lights  = lights_of(state_q);
        if (tick) begin
            state_d = next_state(state_q, eff);
        end
    end

endmodule

// File: tb/tb_hazard_light_ctrl.sv
// Directed self-checking bench for hazard_light_ctrl with TICK_DIV = 4.
module tb_hazard_light_ctrl;

    logic       clk;
    logic       reset_n;
    logic [1:0] wind;
    logic [2:0] lights;
    logic       tick;
    logic       illegal;
`ifdef HAZARD_FREEZE_EN
    logic       freeze;
`endif

    int checks;
    int errors;
    int edgeCnt;

    hazard_light_ctrl #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wind    (wind),
`ifdef HAZARD_FREEZE_EN
        .freeze  (freeze),
`endif
        .lights  (lights),
        .tick    (tick),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it, counting edges since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        edgeCnt++;
    endtask

    task automatic stepTo(input int target);
        while (edgeCnt < target) step();
    endtask

    task automatic applyStimulus(input logic [1:0] windVal);
        wind = windVal;
    endtask

    function automatic logic tickExp();
        return ((edgeCnt % 4) == 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] expLights,
                               input logic expTick, input logic expIllegal);
        checks++;
        assert (lights === expLights) else begin
            errors++;
            $error("[TB] FAIL %s lights got %b want %b", tag, lights, expLights);
        end
        checks++;
        assert (tick === expTick) else begin
            errors++;
            $error("[TB] FAIL %s tick got %b want %b", tag, tick, expTick);
        end
        checks++;
        assert (illegal === expIllegal) else begin
            errors++;
            $error("[TB] FAIL %s illegal got %b want %b", tag, illegal, expIllegal);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        edgeCnt = 0;
        reset_n = 1'b0;
        wind    = 2'b00;
`ifdef HAZARD_FREEZE_EN
        freeze  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("in_reset", 3'b101, 1'b0, 1'b0);
        reset_n = 1'b1;
        edgeCnt = 0;
        checkOutput("release_c0", 3'b101, 1'b0, 1'b0);
        step(); checkOutput("release_c1", 3'b101, 1'b0, 1'b0);
        step(); checkOutput("release_c2", 3'b101, 1'b0, 1'b0);
        step(); checkOutput("first_tick_c3", 3'b101, 1'b1, 1'b0);

        // Calm toggling every four cycles
        stepTo(4);  checkOutput("calm_b1", 3'b010, tickExp(), 1'b0);
        stepTo(7);  checkOutput("calm_hold", 3'b010, tickExp(), 1'b0);
        stepTo(8);  checkOutput("calm_a", 3'b101, tickExp(), 1'b0);
        stepTo(12); checkOutput("calm_b2", 3'b010, tickExp(), 1'b0);
        stepTo(16); checkOutput("calm_a2", 3'b101, tickExp(), 1'b0);

        // Right-to-left from S_CALM_A
        applyStimulus(2'b01);
        stepTo(19); checkOutput("rl_pre_tick", 3'b101, tickExp(), 1'b0);
        stepTo(20); checkOutput("rl_r", 3'b001, tickExp(), 1'b0);
        stepTo(24); checkOutput("rl_m", 3'b010, tickExp(), 1'b0);
        stepTo(28); checkOutput("rl_l", 3'b100, tickExp(), 1'b0);
        stepTo(32); checkOutput("rl_r2", 3'b001, tickExp(), 1'b0);
        stepTo(36); checkOutput("rl_m2", 3'b010, tickExp(), 1'b0);

        // Reversal while in S_M
        applyStimulus(2'b10);
        stepTo(40); checkOutput("rev_r", 3'b001, tickExp(), 1'b0);
        stepTo(44); checkOutput("rev_l", 3'b100, tickExp(), 1'b0);
        stepTo(48); checkOutput("rev_m", 3'b010, tickExp(), 1'b0);

        // Back to RL to reach S_R
        applyStimulus(2'b01);
        stepTo(52); checkOutput("rl_back_l", 3'b100, tickExp(), 1'b0);
        stepTo(56); checkOutput("rl_back_r", 3'b001, tickExp(), 1'b0);

        // Illegal input continues RL sequence
        applyStimulus(2'b11);
        stepTo(59); checkOutput("ill_pre", 3'b001, tickExp(), 1'b0);
        stepTo(60); checkOutput("ill_m", 3'b010, tickExp(), 1'b1);
        stepTo(64); checkOutput("ill_l", 3'b100, tickExp(), 1'b1);
        stepTo(68); checkOutput("ill_r", 3'b001, tickExp(), 1'b1);
        applyStimulus(2'b00);
        stepTo(71); checkOutput("ill_hold", 3'b001, tickExp(), 1'b1);
        stepTo(72); checkOutput("ill_clear", 3'b101, tickExp(), 1'b0);

        // One-cycle glitch between ticks must be ignored
        applyStimulus(2'b10);
        step();
        applyStimulus(2'b00);
        stepTo(76); checkOutput("glitch_b", 3'b010, tickExp(), 1'b0);
        stepTo(80); checkOutput("glitch_a", 3'b101, tickExp(), 1'b0);

        // Change one cycle before the tick cycle is too late for that tick
        stepTo(82);
        applyStimulus(2'b10);
        stepTo(84); checkOutput("late_calm_b", 3'b010, tickExp(), 1'b0);
        stepTo(88); checkOutput("late_lr_l", 3'b100, tickExp(), 1'b0);

        // Asynchronous reset mid-sequence
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 3'b101, 1'b0, 1'b0);
        applyStimulus(2'b00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edgeCnt = 0;
        checkOutput("rerel_c0", 3'b101, 1'b0, 1'b0);
        stepTo(2); checkOutput("rerel_c2", 3'b101, tickExp(), 1'b0);
        stepTo(3); checkOutput("rerel_c3", 3'b101, tickExp(), 1'b0);
        stepTo(4); checkOutput("rerel_c4", 3'b010, tickExp(), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
